// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD block: FSM state encoding and default operand width.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } gcd_state_e;

endpackage

// File: rtl/gcd_controller.sv
// GCD sequencing FSM: operand loads, subtract-step selection and a registered done flag.
module gcd_controller
    import gcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic gt,
    input  logic lt,
    input  logic eq,
    input  logic zero,
    output logic ldA,
    output logic ldB,
    output logic sel_in,
    output logic done
);

    gcd_state_e state_q, state_d;
    logic       done_q, done_d;

    // sel_in is low only in COMPUTE, so the datapath can also use it as the compute-cycle strobe.
    always_comb begin
        state_d = state_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        sel_in  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                ldA     = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                ldB     = 1'b1;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                sel_in = 1'b0;
                if (zero) begin
                    ldA     = 1'b1;
                    state_d = S_DONE;
                end else if (eq) begin
                    state_d = S_DONE;
                end else if (gt) begin
                    ldA = 1'b1;
                end else if (lt) begin
                    ldB = 1'b1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath (A/B registers, comparator, subtractors) around gcd_controller.
// Optional COMPUTE-cycle counter output enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
`ifdef GCD_CYCLE_COUNT_EN
    output logic [WIDTH-1:0] cycle_cnt,
`endif
    output logic             done,
    output logic [WIDTH-1:0] gcd_out
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             gt, lt, eq, zero;
    logic             ld_a, ld_b, sel_in;

    assign zero = (a_q == '0) || (b_q == '0);
    assign eq   = (a_q == b_q);
    assign gt   = (a_q > b_q);
    assign lt   = (a_q < b_q);

    gcd_controller u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .zero   (zero),
        .ldA    (ld_a),
        .ldB    (ld_b),
        .sel_in (sel_in),
        .done   (done)
    );

    // With one operand zero, A|B is simply the other operand, which is the GCD.
    always_comb begin
        a_d = a_q;
        if (ld_a) begin
            if (sel_in) begin
                a_d = data_in;
            end else if (zero) begin
                a_d = a_q | b_q;
            end else begin
                a_d = a_q - b_q;
            end
        end
    end

    always_comb begin
        b_d = b_q;
        if (ld_b) begin
            b_d = sel_in ? data_in : (b_q - a_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign gcd_out = a_q;

`ifdef GCD_CYCLE_COUNT_EN
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_b && sel_in) begin
            cnt_d = '0;
        end else if (!sel_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed, table-driven bench for gcd_datapath (cycle_cnt checks when GCD_CYCLE_COUNT_EN is defined).
module tb_gcd_datapath;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic        done;
    logic [15:0] gcd_out;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;
`endif

    int passed = 0;
    int total  = 0;

    gcd_datapath #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
`ifdef GCD_CYCLE_COUNT_EN
        .cycle_cnt (cycle_cnt),
`endif
        .done      (done),
        .gcd_out   (gcd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_gcd;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Called right after the B-load edge; counts edges until done rises.
    task automatic wait_done(input string name, input logic [15:0] exp_g, input int exp_cyc, input int bound);
        int cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) got = 1'b1;
        end
        chk({name, " done_seen"}, 32'(got), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(exp_cyc));
        chk({name, " gcd"}, 32'(gcd_out), 32'(exp_g));
`ifdef GCD_CYCLE_COUNT_EN
        chk({name, " cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cyc));
`endif
    endtask

    // Leaves DONE/IDLE via a start-low phase, then loads A and B.
    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin
            data_in = a;
            start   = 1'b0;
        end
        @(negedge clk) data_in = b;
        @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{16'd143,   16'd78,    16'd13, 7};
        vecs[1] = '{16'd48,    16'd48,    16'd48, 1};
        vecs[2] = '{16'd0,     16'd35,    16'd35, 1};
        vecs[3] = '{16'd35,    16'd0,     16'd35, 1};
        vecs[4] = '{16'd0,     16'd0,     16'd0,  1};
        vecs[5] = '{16'd21,    16'd14,    16'd7,  3};
        vecs[6] = '{16'd17,    16'd5,     16'd1,  7};
        vecs[7] = '{16'd100,   16'd75,    16'd25, 4};
        vecs[8] = '{16'd12,    16'd18,    16'd6,  3};
        vecs[9] = '{16'd65535, 16'd1,     16'd1,  65535};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #1;
        chk("reset done", 32'(done), 32'd0);
        chk("reset gcd_out", 32'(gcd_out), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("reset cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
        #1 rst_n = 1'b1;
        #1 start = 1'b1;
        #9 data_in = 16'd143;
        #10 data_in = 16'd78;
        #68;
        chk("t90 done low", 32'(done), 32'd0);
        #6;
        chk("t96 done high", 32'(done), 32'd1);
        chk("t96 gcd", 32'(gcd_out), 32'd13);
`ifdef GCD_CYCLE_COUNT_EN
        chk("t96 cycle_cnt", 32'(cycle_cnt), 32'd7);
`endif
        #20;
        chk("start held done", 32'(done), 32'd1);
        chk("start held gcd", 32'(gcd_out), 32'd13);
        #4 start = 1'b0;
        #6;
        chk("start low leaves done", 32'(done), 32'd0);
        chk("idle holds A", 32'(gcd_out), 32'd13);
        #4 start = 1'b1;
        #10 data_in = 16'd12;
        #10 data_in = 16'd18;
        @(posedge clk);
        wait_done("restart 12,18", 16'd6, 3, 200);

        for (int i = 0; i < 10; i++) begin
            load_ops(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d %0d,%0d", i, vecs[i].a, vecs[i].b),
                      vecs[i].exp_gcd, vecs[i].exp_cycles, vecs[i].exp_cycles + 100);
        end

        load_ops(16'd143, 16'd78);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid compute A", 32'(gcd_out), 32'd65);
        chk("mid compute done", 32'(done), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort done", 32'(done), 32'd0);
        chk("abort gcd", 32'(gcd_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post-abort idle done", 32'(done), 32'd0);
        chk("post-abort idle gcd", 32'(gcd_out), 32'd0);
        load_ops(16'd21, 16'd14);
        wait_done("after abort 21,14", 16'd7, 3, 200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
